// File: rtl/isa_pkg.sv
// Shared MIPS-style ISA constants: field positions, R-type opcode, NOP and PC step.
package isa_pkg;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0]  OPC_RTYPE = 6'b000000;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

  // Replicate bit 15 of a 16-bit immediate into the upper half.
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction
endpackage

// File: rtl/if_id_stage_if.sv
// Handshake and decoded-field bundle between fetch, the IF/ID stage and decode.
interface if_id_stage_if #(parameter int PC_W = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_pc_plus4;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [31:0]     out_imm_sext;
  logic            out_is_rtype;

  // Stage view: consumes fetch requests, produces decode-side fields.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_plus4,
           out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm_sext, out_is_rtype
  );

  // Environment view: fetch + decode around the stage.
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_plus4,
           out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm_sext, out_is_rtype
  );
endinterface

// File: rtl/if_id_stage_field_split.sv
// Pure combinational split of a 32-bit instruction word into its fields.
module instr_field_split
  import isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic        is_rtype
);
  assign opcode   = instr[OPC_HI:OPC_LO];
  assign rs       = instr[RS_HI:RS_LO];
  assign rt       = instr[RT_HI:RT_LO];
  assign rd       = instr[RD_HI:RD_LO];
  assign shamt    = instr[SH_HI:SH_LO];
  assign funct    = instr[FN_HI:FN_LO];
  assign imm_sext = sext16(instr[IMM_HI:IMM_LO]);
  assign is_rtype = (instr[OPC_HI:OPC_LO] == OPC_RTYPE);
endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: 2-entry skid buffer (main + skid) with registered in_ready,
// synchronous flush, and decoded fields presented from the main entry.
module if_id_stage
  import isa_pkg::*;
#(
  parameter int          PC_W        = 32,
  parameter logic [31:0] RESET_INSTR = NOP
) (
  input logic           clk,
  input logic           reset,
  if_id_stage_if.slave  bus
);
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  logic   main_v, skid_v;
  entry_t main_e, skid_e, in_e;
  logic   acc, pop;

  assign in_e = '{instr: bus.in_instr, pc: bus.in_pc};
  // in_ready comes straight from a flop so out_ready never reaches it combinationally.
  assign acc  = bus.in_valid && !skid_v;
  assign pop  = main_v && bus.out_ready;

  // Buffer update: flush beats everything; skid drains before new input refills main.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_e <= '{instr: RESET_INSTR, pc: '0};
      skid_e <= '{instr: RESET_INSTR, pc: '0};
    end else if (bus.flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || pop) begin
      if (skid_v) begin
        main_e <= skid_e;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_e <= in_e;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      skid_e <= in_e;
      skid_v <= 1'b1;
    end
  end

  assign bus.in_ready     = !skid_v;
  assign bus.out_valid    = main_v;
  assign bus.out_instr    = main_e.instr;
  assign bus.out_pc       = main_e.pc;
  assign bus.out_pc_plus4 = main_e.pc + PC_W'(PC_INC);

  logic [5:0]  f_opcode, f_funct;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [31:0] f_imm;
  logic        f_rtype;

  instr_field_split u_split (
    .instr    (main_e.instr),
    .opcode   (f_opcode),
    .rs       (f_rs),
    .rt       (f_rt),
    .rd       (f_rd),
    .shamt    (f_shamt),
    .funct    (f_funct),
    .imm_sext (f_imm),
    .is_rtype (f_rtype)
  );

  assign bus.out_opcode   = f_opcode;
  assign bus.out_rs       = f_rs;
  assign bus.out_rt       = f_rt;
  assign bus.out_rd       = f_rd;
  assign bus.out_shamt    = f_shamt;
  assign bus.out_funct    = f_funct;
  assign bus.out_imm_sext = f_imm;
  assign bus.out_is_rtype = f_rtype;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: field-decode vector table plus handshake sequences.
module tb_if_id_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  if_id_stage_if #(.PC_W(32)) bus ();

  if_id_stage #(.PC_W(32), .RESET_INSTR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic        rtype;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h012A4020, 32'h0000_0000, 32'h0000_0004, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 32'h0000_4020, 1'b1};
    vecs[1] = '{32'h8D28FFFC, 32'h0000_0004, 32'h0000_0008, 6'h23, 5'd9, 5'd8,  5'd31, 5'd31, 6'h3C, 32'hFFFF_FFFC, 1'b0};
    vecs[2] = '{32'h21080005, 32'h0000_0008, 32'h0000_000C, 6'h08, 5'd8, 5'd8,  5'd0,  5'd0,  6'h05, 32'h0000_0005, 1'b0};
    vecs[3] = '{32'h3C018000, 32'h0000_1000, 32'h0000_1004, 6'h0F, 5'd0, 5'd1,  5'd16, 5'd0,  6'h00, 32'hFFFF_8000, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 6'h00, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h7FFF_FFF8, 32'h7FFF_FFFC, 6'h00, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 32'h0000_0000, 1'b1};

    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hDEAD_BEEF;
    bus.in_pc = 32'h0000_0200;
    bus.out_ready = 1'b0;

    // Reset held with fetch presenting data: nothing may be captured.
    tick(); tick();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_pc_plus4", bus.out_pc_plus4, 32'd4);

    // First accept after release shows up one cycle later.
    bus.in_pc = 32'h0000_0100;
    reset = 1'b1;
    chk("pre_acc_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("first_acc_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("first_acc_pc", bus.out_pc, 32'h0000_0100);
    chk("first_acc_instr", bus.out_instr, 32'hDEAD_BEEF);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("first_drain", {31'b0, bus.out_valid}, 32'd0);

    // Field decode table.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      bus.in_pc = vecs[i].pc;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("v%0d_instr", i), bus.out_instr, vecs[i].instr);
      chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].pc);
      chk($sformatf("v%0d_pc4", i), bus.out_pc_plus4, vecs[i].pc4);
      chk($sformatf("v%0d_opc", i), {26'b0, bus.out_opcode}, {26'b0, vecs[i].opc});
      chk($sformatf("v%0d_rs", i), {27'b0, bus.out_rs}, {27'b0, vecs[i].rs});
      chk($sformatf("v%0d_rt", i), {27'b0, bus.out_rt}, {27'b0, vecs[i].rt});
      chk($sformatf("v%0d_rd", i), {27'b0, bus.out_rd}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_sh", i), {27'b0, bus.out_shamt}, {27'b0, vecs[i].sh});
      chk($sformatf("v%0d_fn", i), {26'b0, bus.out_funct}, {26'b0, vecs[i].fn});
      chk($sformatf("v%0d_imm", i), bus.out_imm_sext, vecs[i].imm);
      chk($sformatf("v%0d_rtype", i), {31'b0, bus.out_is_rtype}, {31'b0, vecs[i].rtype});
      tick();
      chk($sformatf("v%0d_empty", i), {31'b0, bus.out_valid}, 32'd0);
    end

    // Back-pressure: 0x00 to main, 0x04 to skid, 0x08 held by fetch.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h1111_0000;
    bus.in_pc = 32'h0000_0000;
    tick();
    chk("bp_rdy_after1", {31'b0, bus.in_ready}, 32'd1);
    bus.in_instr = 32'h1111_0004;
    bus.in_pc = 32'h0000_0004;
    tick();
    chk("bp_rdy_after2", {31'b0, bus.in_ready}, 32'd0);
    chk("bp_head0", bus.out_pc, 32'h0000_0000);
    bus.in_instr = 32'h1111_0008;
    bus.in_pc = 32'h0000_0008;
    tick();
    chk("bp_hold_pc", bus.out_pc, 32'h0000_0000);
    chk("bp_hold_instr", bus.out_instr, 32'h1111_0000);
    chk("bp_hold_rdy", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out1_pc", bus.out_pc, 32'h0000_0004);
    chk("bp_out1_instr", bus.out_instr, 32'h1111_0004);
    chk("bp_out1_valid", {31'b0, bus.out_valid}, 32'd1);
    tick();
    chk("bp_out2_pc", bus.out_pc, 32'h0000_0008);
    chk("bp_out2_instr", bus.out_instr, 32'h1111_0008);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    // Flush with both entries full and a same-cycle input.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h0000_0010;
    tick();
    bus.in_pc = 32'h0000_0014;
    tick();
    chk("fl_full", {31'b0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    bus.in_pc = 32'h0000_0018;
    tick();
    bus.flush = 1'b0;
    chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_pc = 32'h0000_0040;
    tick();
    bus.in_valid = 1'b0;
    chk("fl_next_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("fl_next_pc", bus.out_pc, 32'h0000_0040);
    bus.out_ready = 1'b1;
    tick();
    chk("fl_drained", {31'b0, bus.out_valid}, 32'd0);

    // Async reset mid-stream drops out_valid before the next edge.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h0000_0080;
    tick();
    chk("ar_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("ar_pc", bus.out_pc, 32'd0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("ar_after", {31'b0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
